// File: rtl/wbus_writeback.sv
// W-bus consumer: stages a W-bus value, commits it into the register file and
// raises a PC-load request towards fetch when R7 is written.
module wbus_writeback #(
  parameter int BITS     = 16,
  parameter int REG_ADDR = 3
) (
  input  logic                clk,
  input  logic                rst,
  // Handshake: a write transfers on a rising edge where wb_valid && wb_ready;
  // the source holds wb_valid and its data until then, wb_valid alone is ignored.
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [BITS-1:0]     wBusIn,
  input  logic [REG_ADDR-1:0] wb_dest,
  input  logic                wb_we,
  input  logic [REG_ADDR-1:0] rd_addr_a,
  input  logic [REG_ADDR-1:0] rd_addr_b,
  output logic [BITS-1:0]     rd_data_a,
  output logic [BITS-1:0]     rd_data_b,
  output logic                pc_load,
  output logic [BITS-1:0]     pc_value,
  input  logic                pc_ack,
  output logic [BITS-1:0]     wb_count,
  output logic [1:0]          dbg_state_o
);

  localparam int NREGS = 2 ** REG_ADDR;
  localparam logic [REG_ADDR-1:0] PC_IDX = {REG_ADDR{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMMIT  = 2'd1,
    PC_WAIT = 2'd2
  } state_t;

  state_t              state_q;
  logic [BITS-1:0]     regs_q [NREGS];
  logic [BITS-1:0]     stage_data_q;
  logic [REG_ADDR-1:0] stage_dest_q;
  logic                stage_we_q;
  logic                pc_load_q;
  logic [BITS-1:0]     pc_value_q;
  logic [BITS-1:0]     count_q;
  logic [BITS-1:0]     count_d;
  logic                commit_wr_d;

  // R0 is hardwired to zero, so a write aimed at it is neither stored nor counted.
  assign commit_wr_d = stage_we_q && (stage_dest_q != '0);
  assign count_d     = count_q + {{(BITS-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      stage_data_q <= '0;
      stage_dest_q <= '0;
      stage_we_q   <= 1'b0;
      pc_load_q    <= 1'b0;
      pc_value_q   <= '0;
      count_q      <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wb_valid) begin
            stage_data_q <= wBusIn;
            stage_dest_q <= wb_dest;
            stage_we_q   <= wb_we;
            state_q      <= COMMIT;
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          if (commit_wr_d) begin
            regs_q[stage_dest_q] <= stage_data_q;
            count_q              <= count_d;
            if (stage_dest_q == PC_IDX) begin
              pc_value_q <= stage_data_q;
              pc_load_q  <= 1'b1;
              state_q    <= PC_WAIT;
            end
          end
        end
        PC_WAIT: begin
          if (pc_ack) begin
            pc_load_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The staged value is forwarded during COMMIT so readers never see a stale register.
  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    if (rd_addr_a == '0) rd_data_a = '0;
    else if (state_q == COMMIT && stage_we_q && stage_dest_q == rd_addr_a) rd_data_a = stage_data_q;
  end

  always_comb begin
    rd_data_b = regs_q[rd_addr_b];
    if (rd_addr_b == '0) rd_data_b = '0;
    else if (state_q == COMMIT && stage_we_q && stage_dest_q == rd_addr_b) rd_data_b = stage_data_q;
  end

  assign wb_ready    = (state_q == IDLE);
  assign pc_load     = pc_load_q;
  assign pc_value    = pc_value_q;
  assign wb_count    = count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wbus_writeback.sv
// Directed bench for wbus_writeback: vector table for single writes plus
// hand sequences for PC handshake, back-to-back, reset and counter wrap.
module tb_wbus_writeback;

  localparam int BITS = 16;
  localparam int RA   = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            wb_valid, wb_ready, wb_we, pc_load, pc_ack;
  logic [BITS-1:0] wBusIn, rd_data_a, rd_data_b, pc_value, wb_count;
  logic [RA-1:0]   wb_dest, rd_addr_a, rd_addr_b;
  logic [1:0]      dbg_state;

  wbus_writeback #(.BITS(BITS), .REG_ADDR(RA)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready), .wBusIn(wBusIn),
    .wb_dest(wb_dest), .wb_we(wb_we), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .pc_load(pc_load), .pc_value(pc_value),
    .pc_ack(pc_ack), .wb_count(wb_count), .dbg_state_o(dbg_state)
  );

  // 4-bit instance so the counter wrap is reachable in a few cycles.
  logic       s_valid, s_ready, s_pc_load;
  logic [3:0] s_data, s_rd_a, s_rd_b, s_pc_value, s_count;
  logic [1:0] s_state;

  wbus_writeback #(.BITS(4), .REG_ADDR(RA)) wrap_dut (
    .clk(clk), .rst(rst), .wb_valid(s_valid), .wb_ready(s_ready), .wBusIn(s_data),
    .wb_dest(3'd1), .wb_we(1'b1), .rd_addr_a(3'd1), .rd_addr_b(3'd2),
    .rd_data_a(s_rd_a), .rd_data_b(s_rd_b), .pc_load(s_pc_load), .pc_value(s_pc_value),
    .pc_ack(1'b0), .wb_count(s_count), .dbg_state_o(s_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [BITS-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge inside the COMMIT cycle.
  task automatic send(input logic [RA-1:0] dest, input logic [BITS-1:0] data, input logic we);
    int guard;
    guard = 0;
    while (!wb_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!wb_ready) check("ready_timeout", 32'(wb_ready), 32'd1);
    wb_valid = 1'b1;
    wb_dest  = dest;
    wBusIn   = data;
    wb_we    = we;
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  typedef struct {
    logic [RA-1:0]   dest;
    logic [BITS-1:0] data;
    logic            we;
    logic [BITS-1:0] exp_byp;
    logic [BITS-1:0] exp_after;
    logic [BITS-1:0] exp_count;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  initial begin
    vecs[0] = '{3'd3, 16'hBEEF, 1'b1, 16'hBEEF, 16'hBEEF, 16'd1};
    vecs[1] = '{3'd0, 16'h1234, 1'b1, 16'h0000, 16'h0000, 16'd1};
    vecs[2] = '{3'd5, 16'hAAAA, 1'b0, 16'h0000, 16'h0000, 16'd1};
    vecs[3] = '{3'd1, 16'h0001, 1'b1, 16'h0001, 16'h0001, 16'd2};
    vecs[4] = '{3'd6, 16'hFFFF, 1'b1, 16'hFFFF, 16'hFFFF, 16'd3};
    vecs[5] = '{3'd5, 16'h5A5A, 1'b1, 16'h5A5A, 16'h5A5A, 16'd4};
    vecs[6] = '{3'd5, 16'h1111, 1'b0, 16'h5A5A, 16'h5A5A, 16'd4};
    vecs[7] = '{3'd3, 16'h0123, 1'b1, 16'h0123, 16'h0123, 16'd5};

    rst = 1'b1; wb_valid = 1'b0; wb_we = 1'b0; wb_dest = '0; wBusIn = '0;
    rd_addr_a = 3'd3; rd_addr_b = 3'd7; pc_ack = 1'b0;
    s_valid = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(wb_ready), 32'd1);
    check("rst_pc_load", 32'(pc_load), 32'd0);
    check("rst_count", 32'(wb_count), 32'd0);
    check("rst_rd_a", 32'(rd_data_a), 32'd0);

    // ---- single-write vector table ----
    for (int i = 0; i < NV; i++) begin
      exp_q.push_back(vecs[i].exp_byp);
      exp_q.push_back(vecs[i].exp_after);
      rd_addr_a = vecs[i].dest;
      rd_addr_b = vecs[i].dest;
      send(vecs[i].dest, vecs[i].data, vecs[i].we);
      check($sformatf("v%0d_commit_ready", i), 32'(wb_ready), 32'd0);
      check($sformatf("v%0d_commit_state", i), 32'(dbg_state), 32'd1);
      check($sformatf("v%0d_bypass_b", i), 32'(rd_data_b), 32'(exp_q[0]));
      check($sformatf("v%0d_bypass_a", i), 32'(rd_data_a), 32'(exp_q.pop_front()));
      @(negedge clk);
      check($sformatf("v%0d_ready_back", i), 32'(wb_ready), 32'd1);
      check($sformatf("v%0d_array", i), 32'(rd_data_a), 32'(exp_q.pop_front()));
      check($sformatf("v%0d_count", i), 32'(wb_count), 32'(vecs[i].exp_count));
    end

    // ---- R7 write and PC handshake ----
    rd_addr_a = 3'd7;
    send(3'd7, 16'h0040, 1'b1);
    check("r7_bypass", 32'(rd_data_a), 32'h0040);
    check("r7_commit_pc_load", 32'(pc_load), 32'd0);
    @(negedge clk);
    check("r7_pc_load", 32'(pc_load), 32'd1);
    check("r7_pc_value", 32'(pc_value), 32'h0040);
    check("r7_count", 32'(wb_count), 32'd6);
    check("r7_array", 32'(rd_data_a), 32'h0040);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("r7_hold%0d_load", c), 32'(pc_load), 32'd1);
      check($sformatf("r7_hold%0d_value", c), 32'(pc_value), 32'h0040);
      check($sformatf("r7_hold%0d_ready", c), 32'(wb_ready), 32'd0);
    end
    pc_ack = 1'b1;
    @(negedge clk);
    pc_ack = 1'b0;
    check("r7_ack_load", 32'(pc_load), 32'd0);
    check("r7_ack_ready", 32'(wb_ready), 32'd1);
    check("r7_after_ack", 32'(rd_data_a), 32'h0040);

    // ---- back-to-back with wb_valid held high ----
    rd_addr_a = 3'd1; rd_addr_b = 3'd2;
    wb_valid = 1'b1; wb_we = 1'b1; wb_dest = 3'd1; wBusIn = 16'h0001;
    @(negedge clk);
    check("b2b_first_commit", 32'(wb_ready), 32'd0);
    wb_dest = 3'd2; wBusIn = 16'h0002;
    @(negedge clk);
    check("b2b_idle_gap", 32'(wb_ready), 32'd1);
    check("b2b_r1", 32'(rd_data_a), 32'h0001);
    check("b2b_r2_not_yet", 32'(rd_data_b), 32'h0000);
    @(negedge clk);
    wb_valid = 1'b0;
    check("b2b_second_commit", 32'(wb_ready), 32'd0);
    check("b2b_r2_bypass", 32'(rd_data_b), 32'h0002);
    rd_addr_a = 3'd3;
    #1;
    check("b2b_other_port_array", 32'(rd_data_a), 32'h0123);
    @(negedge clk);
    check("b2b_r2", 32'(rd_data_b), 32'h0002);
    check("b2b_count", 32'(wb_count), 32'd8);

    // ---- pc_ack with no request pending ----
    pc_ack = 1'b1;
    repeat (2) @(negedge clk);
    check("stray_ack_load", 32'(pc_load), 32'd0);
    check("stray_ack_state", 32'(dbg_state), 32'd0);
    pc_ack = 1'b0;

    // ---- reset while waiting for pc_ack ----
    send(3'd7, 16'h0080, 1'b1);
    @(negedge clk);
    check("pre_rst_pc_load", 32'(pc_load), 32'd1);
    rst = 1'b1;
    rd_addr_a = 3'd3; rd_addr_b = 3'd7;
    #1;
    check("mid_rst_rd_a", 32'(rd_data_a), 32'd0);
    check("mid_rst_rd_b", 32'(rd_data_b), 32'd0);
    check("mid_rst_ready", 32'(wb_ready), 32'd1);
    check("mid_rst_pc_load", 32'(pc_load), 32'd0);
    check("mid_rst_pc_value", 32'(pc_value), 32'd0);
    check("mid_rst_count", 32'(wb_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ---- counter wrap on the 4-bit instance ----
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1;
      s_data  = 4'(i);
      @(negedge clk);
      s_valid = 1'b0;
      @(negedge clk);
      if (i == 15) check("wrap_count_max", 32'(s_count), 32'hF);
    end
    check("wrap_count_zero", 32'(s_count), 32'd0);
    check("wrap_last_data", 32'(s_rd_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
